// File: rtl/baud_rate_sequencer_pkg.sv
// Shared constants for the baud-rate sequencer: the rate table, the
// elaboration-time period helper and the FSM state type.
package baud_seq_pkg;

  localparam int unsigned MAX_RATES = 13;

  // Index 0..7 double from 300 baud; index 8..12 double from 57600 baud.
  localparam int unsigned RATE_HZ [MAX_RATES] = '{
    300, 600, 1200, 2400, 4800, 9600, 19200, 38400,
    57600, 115200, 230400, 460800, 921600
  };

  // Clock ticks per bit, truncated. Only ever evaluated at elaboration.
  function automatic int unsigned periodFor(input int unsigned clockSpeed,
                                            input int unsigned index);
    if (index >= MAX_RATES) return 0;
    return clockSpeed / RATE_HZ[index[3:0]];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_APPLY   = 2'd2
  } seqState_t;

endpackage

// File: rtl/baud_rate_sequencer_if.sv
// Request/status bundle between the UART control logic and the sequencer.
interface baud_rate_sequencer_if #(
  parameter int PERIOD_W = 20
);
  logic                i_Step_Up;
  logic                i_Step_Down;
  logic                i_Load;
  logic [4:0]          i_Load_Index;
  logic                i_Line_Idle;
  logic [PERIOD_W-1:0] o_Period;
  logic [4:0]          o_Index;
  logic                o_Changed;
  logic                o_Pending;
  logic                o_Error;
  logic                o_Baud_Tick;

  modport master (
    output i_Step_Up, i_Step_Down, i_Load, i_Load_Index, i_Line_Idle,
    input  o_Period, o_Index, o_Changed, o_Pending, o_Error, o_Baud_Tick
  );

  modport slave (
    input  i_Step_Up, i_Step_Down, i_Load, i_Load_Index, i_Line_Idle,
    output o_Period, o_Index, o_Changed, o_Pending, o_Error, o_Baud_Tick
  );
endinterface

// File: rtl/baud_rate_sequencer_tick_gen.sv
// Bit-rate strobe: one-cycle pulse every i_Period clocks, phase reset by
// i_Restart so the first tick after a rate change is a full period later.
module baud_tick_gen #(
  parameter int PERIOD_W = 20
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Restart,
  input  logic [PERIOD_W-1:0] i_Period,
  output logic                o_Tick
);

  logic [PERIOD_W-1:0] count;
  logic                termCount;

  assign termCount = (count == (i_Period - PERIOD_W'(1)));

  // Free-running period counter with registered terminal-count strobe.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count  <= '0;
      o_Tick <= 1'b0;
    end else if (i_Restart) begin
      count  <= '0;
      o_Tick <= 1'b0;
    end else if (termCount) begin
      count  <= '0;
      o_Tick <= 1'b1;
    end else begin
      count  <= count + PERIOD_W'(1);
      o_Tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_rate_sequencer.sv
// Baud-rate sequencer: holds the current rate index and its period, and
// applies step/load requests only while the serial line is idle.
// Optional macro BAUD_SEQ_TICKGEN_EN adds the o_Baud_Tick strobe generator;
// without it o_Baud_Tick is tied low.
//
// state     | meaning
// S_IDLE    | accepting requests, no change outstanding
// S_PENDING | target latched, waiting for i_Line_Idle
// S_APPLY   | committing target to o_Index/o_Period this cycle
module baud_rate_sequencer
  import baud_seq_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 25000000,
  parameter int          NUM_RATES   = 13,
  parameter int          PERIOD_W    = 20,
  parameter int unsigned RESET_INDEX = 9,
  parameter int          WRAP        = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  baud_rate_sequencer_if.slave  bus
);

  localparam logic [4:0] LAST_IDX   = 5'(NUM_RATES - 1);
  localparam logic [4:0] RATE_COUNT = 5'(NUM_RATES);
  localparam logic [4:0] RESET_IDX  = 5'(RESET_INDEX);
  localparam logic [PERIOD_W-1:0] RESET_PERIOD =
    PERIOD_W'(periodFor(CLOCK_SPEED, RESET_INDEX));

  // Period ROM sized to the full 5-bit index space; unused slots read 0.
  logic [PERIOD_W-1:0] periodRom [32];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    if (g < NUM_RATES) begin : g_used
      assign periodRom[g] = PERIOD_W'(periodFor(CLOCK_SPEED, g));
    end else begin : g_unused
      assign periodRom[g] = '0;
    end
  end

  seqState_t           stateReg, nextState;
  logic [4:0]          indexReg, targetReg, reqTarget;
  logic [PERIOD_W-1:0] periodReg;
  logic                changedReg, pendingReg, errorReg, baudTick;
  logic                reqValid, reqError, latchReq, applyNow;

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) stateReg <= S_IDLE;
    else          stateReg <= nextState;
  end

  // Next-state logic, including request decode and target computation.
  always_comb begin
    nextState = stateReg;
    reqValid  = 1'b0;
    reqError  = 1'b0;
    reqTarget = indexReg;
    case (stateReg)
      S_IDLE: begin
        if (bus.i_Load) begin
          if (bus.i_Load_Index >= RATE_COUNT) begin
            reqError = 1'b1;
          end else begin
            reqValid  = 1'b1;
            reqTarget = bus.i_Load_Index;
          end
        end else if (bus.i_Step_Up && !bus.i_Step_Down) begin
          if (indexReg != LAST_IDX) begin
            reqValid  = 1'b1;
            reqTarget = indexReg + 5'd1;
          end else if (WRAP != 0) begin
            reqValid  = 1'b1;
            reqTarget = 5'd0;
          end
        end else if (bus.i_Step_Down && !bus.i_Step_Up) begin
          if (indexReg != 5'd0) begin
            reqValid  = 1'b1;
            reqTarget = indexReg - 5'd1;
          end else if (WRAP != 0) begin
            reqValid  = 1'b1;
            reqTarget = LAST_IDX;
          end
        end
        if (reqValid) nextState = S_PENDING;
      end
      S_PENDING: if (bus.i_Line_Idle) nextState = S_APPLY;
      S_APPLY:   nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  // Output decode: when to latch a target and when to commit it.
  always_comb begin
    latchReq = (stateReg == S_IDLE) && reqValid;
    applyNow = (stateReg == S_APPLY);
  end

  // Registered outputs; nothing reaches the ports combinationally.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      indexReg   <= RESET_IDX;
      periodReg  <= RESET_PERIOD;
      targetReg  <= RESET_IDX;
      changedReg <= 1'b0;
      pendingReg <= 1'b0;
      errorReg   <= 1'b0;
    end else begin
      changedReg <= applyNow;
      errorReg   <= reqError;
      if (latchReq) begin
        targetReg  <= reqTarget;
        pendingReg <= 1'b1;
      end
      if (applyNow) begin
        indexReg   <= targetReg;
        periodReg  <= periodRom[targetReg];
        pendingReg <= 1'b0;
      end
    end
  end

`ifdef BAUD_SEQ_TICKGEN_EN
  baud_tick_gen #(.PERIOD_W(PERIOD_W)) u_tickGen (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Restart (applyNow),
    .i_Period  (periodReg),
    .o_Tick    (baudTick)
  );
`else
  assign baudTick = 1'b0;
`endif

  assign bus.o_Index     = indexReg;
  assign bus.o_Period    = periodReg;
  assign bus.o_Changed   = changedReg;
  assign bus.o_Pending   = pendingReg;
  assign bus.o_Error     = errorReg;
  assign bus.o_Baud_Tick = baudTick;

endmodule

// File: tb/tb_baud_rate_sequencer.sv
// Bench for baud_rate_sequencer: a wrapping and a saturating instance driven
// with identical stimulus, each checked against a transaction-level model.
module tb_baud_rate_sequencer;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  baud_rate_sequencer_if #(.PERIOD_W(20)) bw ();
  baud_rate_sequencer_if #(.PERIOD_W(20)) bs ();

  baud_rate_sequencer #(.CLOCK_SPEED(25000000), .NUM_RATES(13), .PERIOD_W(20),
                        .RESET_INDEX(9), .WRAP(1)) dutWrap (
    .i_Clk(clk), .i_Rst_L(rstN), .bus(bw.slave));

  baud_rate_sequencer #(.CLOCK_SPEED(25000000), .NUM_RATES(13), .PERIOD_W(20),
                        .RESET_INDEX(9), .WRAP(0)) dutSat (
    .i_Clk(clk), .i_Rst_L(rstN), .bus(bs.slave));

  int checks = 0;
  int failures = 0;
  int mIdx [2];

  int obsIdx [2];
  int obsPer [2];
  bit obsChg [2];
  bit obsPend [2];
  bit obsErr [2];
  bit obsTick [2];

  always_comb begin
    obsIdx[0]  = int'(bw.o_Index);   obsIdx[1]  = int'(bs.o_Index);
    obsPer[0]  = int'(bw.o_Period);  obsPer[1]  = int'(bs.o_Period);
    obsChg[0]  = bw.o_Changed;       obsChg[1]  = bs.o_Changed;
    obsPend[0] = bw.o_Pending;       obsPend[1] = bs.o_Pending;
    obsErr[0]  = bw.o_Error;         obsErr[1]  = bs.o_Error;
    obsTick[0] = bw.o_Baud_Tick;     obsTick[1] = bs.o_Baud_Tick;
  end

  task automatic drive(input bit up, input bit down, input bit load,
                       input int li, input bit idle);
    bw.i_Step_Up = up;  bw.i_Step_Down = down;  bw.i_Load = load;
    bw.i_Load_Index = 5'(li);  bw.i_Line_Idle = idle;
    bs.i_Step_Up = up;  bs.i_Step_Down = down;  bs.i_Load = load;
    bs.i_Load_Index = 5'(li);  bs.i_Line_Idle = idle;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rate in baud from the table rule, then period = 25 MHz / rate.
  function automatic int refPeriod(input int idx);
    int rate;
    rate = (idx < 8) ? 300 * (1 << idx) : 57600 * (1 << (idx - 8));
    return 25000000 / rate;
  endfunction

  function automatic void refReq(input int idx, input bit up, input bit down,
                                 input bit load, input int li, input bit wrap,
                                 output bit valid, output int tgt, output bit err);
    valid = 0; err = 0; tgt = idx;
    if (load) begin
      if (li >= 13) err = 1;
      else begin valid = 1; tgt = li; end
    end else if (up && !down) begin
      if (idx < 12) begin valid = 1; tgt = idx + 1; end
      else if (wrap) begin valid = 1; tgt = 0; end
    end else if (down && !up) begin
      if (idx > 0) begin valid = 1; tgt = idx - 1; end
      else if (wrap) begin valid = 1; tgt = 12; end
    end
  endfunction

  // One request, waitCyc busy-line cycles, then idle until committed.
  task automatic run_txn(input string tag, input bit up, input bit down,
                         input bit load, input int li, input int waitCyc,
                         input bit noise);
    bit v [2];
    int t [2];
    bit e [2];
    int expIdx;
    for (int d = 0; d < 2; d++)
      refReq(mIdx[d], up, down, load, li, (d == 0), v[d], t[d], e[d]);
    drive(up, down, load, li, 1'b1);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsPend[d] !== v[d] || obsErr[d] !== e[d] || obsChg[d] !== 1'b0 ||
          obsIdx[d] !== mIdx[d]) begin
        failures++;
        $display("FAIL %s dut%0d accept: got pend=%0d err=%0d chg=%0d idx=%0d expected pend=%0d err=%0d chg=0 idx=%0d",
                 tag, d, obsPend[d], obsErr[d], obsChg[d], obsIdx[d], v[d], e[d], mIdx[d]);
      end
    end
    for (int w = 0; w < waitCyc; w++) begin
      drive(noise && v[0] && v[1], 1'b0, 1'b0, 0, 1'b0);
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obsPend[d] !== v[d] || obsChg[d] !== 1'b0 || obsIdx[d] !== mIdx[d]) begin
          failures++;
          $display("FAIL %s dut%0d wait%0d: got pend=%0d chg=%0d idx=%0d expected pend=%0d chg=0 idx=%0d",
                   tag, d, w, obsPend[d], obsChg[d], obsIdx[d], v[d], mIdx[d]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsPend[d] !== v[d] || obsChg[d] !== 1'b0 || obsErr[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d idle-edge: got pend=%0d chg=%0d err=%0d expected pend=%0d chg=0 err=0",
                 tag, d, obsPend[d], obsChg[d], obsErr[d], v[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      expIdx = v[d] ? t[d] : mIdx[d];
      checks++;
      if (obsIdx[d] !== expIdx || obsPer[d] !== refPeriod(expIdx) ||
          obsChg[d] !== v[d] || obsPend[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d apply: got idx=%0d per=%0d chg=%0d pend=%0d expected idx=%0d per=%0d chg=%0d pend=0",
                 tag, d, obsIdx[d], obsPer[d], obsChg[d], obsPend[d], expIdx,
                 refPeriod(expIdx), v[d]);
      end
      mIdx[d] = expIdx;
    end
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsChg[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d changed-width: got chg=%0d expected 0", tag, d, obsChg[d]);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    rstN = 1'b0;
    step(); step();
    rstN = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      mIdx[d] = 9;
      checks++;
      if (obsIdx[d] !== 9 || obsPer[d] !== 217 || obsChg[d] !== 1'b0 ||
          obsPend[d] !== 1'b0 || obsErr[d] !== 1'b0 || obsTick[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: got idx=%0d per=%0d chg=%0d pend=%0d err=%0d tick=%0d expected idx=9 per=217 all pulses 0",
                 d, obsIdx[d], obsPer[d], obsChg[d], obsPend[d], obsErr[d], obsTick[d]);
      end
    end
  endtask

  task automatic test_step_up();
    run_txn("step_up", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_txn("load12", 1'b0, 1'b0, 1'b1, 12, 0, 1'b0);
    run_txn("up_from_top", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_txn("load0", 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
    run_txn("down_from_0", 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_load_pending();
    run_txn("load7_busy", 1'b0, 1'b0, 1'b1, 7, 5, 1'b1);
  endtask

  task automatic test_error();
    run_txn("load20", 1'b0, 1'b0, 1'b1, 20, 0, 1'b0);
    run_txn("load13", 1'b0, 1'b0, 1'b1, 13, 2, 1'b0);
  endtask

  task automatic test_both();
    run_txn("up_and_down", 1'b1, 1'b1, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 5: run_txn("rnd_up", 1'b1, 1'b0, 1'b0, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        1: run_txn("rnd_down", 1'b0, 1'b1, 1'b0, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        2: run_txn("rnd_both", 1'b1, 1'b1, 1'b0, 0, int'($urandom_range(0, 3)), 1'b0);
        3: run_txn("rnd_load", 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        default: run_txn("rnd_badload", 1'b0, 1'b0, 1'b1, int'($urandom_range(13, 31)), int'($urandom_range(0, 3)), 1'b0);
      endcase
    end
  endtask

  task automatic test_tick();
    bit tickEn;
    bit expTick;
`ifdef BAUD_SEQ_TICKGEN_EN
    tickEn = 1'b1;
`else
    tickEn = 1'b0;
`endif
    drive(1'b0, 1'b0, 1'b1, 12, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      mIdx[d] = 12;
      checks++;
      if (obsChg[d] !== 1'b1 || obsPer[d] !== 27) begin
        failures++;
        $display("FAIL tick_setup dut%0d: got chg=%0d per=%0d expected chg=1 per=27",
                 d, obsChg[d], obsPer[d]);
      end
    end
    for (int c = 1; c <= 60; c++) begin
      step();
      expTick = tickEn && (c % 27 == 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obsTick[d] !== expTick) begin
          failures++;
          $display("FAIL baud_tick dut%0d cycle%0d: got %0d expected %0d",
                   d, c, obsTick[d], expTick);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 3, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsPend[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_pre dut%0d pending: got %0d expected 1", d, obsPend[d]);
      end
    end
    #2;
    rstN = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      mIdx[d] = 9;
      checks++;
      if (obsPend[d] !== 1'b0 || obsIdx[d] !== 9 || obsPer[d] !== 217 || obsChg[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_async dut%0d: got pend=%0d idx=%0d per=%0d chg=%0d expected pend=0 idx=9 per=217 chg=0",
                 d, obsPend[d], obsIdx[d], obsPer[d], obsChg[d]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    step();
    rstN = 1'b1;
    step(); step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsPend[d] !== 1'b0 || obsIdx[d] !== 9 || obsChg[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_after dut%0d: got pend=%0d idx=%0d chg=%0d expected pend=0 idx=9 chg=0",
                 d, obsPend[d], obsIdx[d], obsChg[d]);
      end
    end
  endtask

  initial begin
    rstN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    test_reset();
    test_step_up();
    test_wrap();
    test_load_pending();
    test_error();
    test_both();
    test_random();
    test_tick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
